// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding,
// stream framing constants and the default load address.
`timescale 1ns/1ps
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  localparam int          HDR_BYTES         = 2;
  localparam int          BYTES_PER_WORD    = 4;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word assembler. Bytes shift in from the bottom so the
// first byte of a word ends up in [31:24]. word_o already includes the byte
// being accepted, so the loader can capture a full word on the same edge
// that the fourth byte arrives.
`timescale 1ns/1ps
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_ready_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  // Next-state for the shift register and byte counter; clear wins over a byte.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (byte_en_i) begin
      word_d = {word_q[23:0], byte_i};
      cnt_d  = cnt_q + 2'd1;
    end
  end

  // Assembly state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o       = {word_q[23:0], byte_i};
  assign word_ready_o = byte_en_i && !clear_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program image into instruction memory while
// holding the CPU. Header is a 16-bit big-endian word count, followed by
// that many big-endian 32-bit words written to consecutive addresses.
`timescale 1ns/1ps
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic        Byte_Valid,
  input  logic [7:0]  Byte_Data,
  output logic        Byte_Ready,
  output logic        IMem_WE,
  output logic [31:0] IMem_Addr,
  output logic [31:0] IMem_WData,
  output logic        Hold_CPU,
  output logic        Done,
  output logic        Error
);

  localparam int IDX_W = $clog2(DEPTH_WORDS + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [15:0]        n_q, n_d;
  logic               hdrCnt_q, hdrCnt_d;
  logic [7:0]         hdrHi_q, hdrHi_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;

  logic               xfer;
  logic               startAccept;
  logic               packEn;
  logic               wordReady;
  logic [31:0]        packWord;
  logic [15:0]        hdrN;

  assign Byte_Ready  = (state_q == ST_HDR) || (state_q == ST_DATA);
  assign xfer        = Byte_Valid && Byte_Ready;
  assign startAccept = Start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                 (state_q == ST_ERR));
  assign packEn      = xfer && (state_q == ST_DATA);
  assign hdrN        = {hdrHi_q, Byte_Data};

  byte_packer u_packer (
    .clk_i        (Clock),
    .rst_ni       (Reset_n),
    .clear_i      (startAccept),
    .byte_en_i    (packEn),
    .byte_i       (Byte_Data),
    .word_o       (packWord),
    .word_ready_o (wordReady)
  );

  // Next-state logic: header decode, word capture and index advance.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    n_d      = n_q;
    hdrCnt_d = hdrCnt_q;
    hdrHi_d  = hdrHi_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (startAccept) begin
          state_d  = ST_HDR;
          idx_d    = '0;
          hdrCnt_d = 1'b0;
        end
      end
      ST_HDR: begin
        if (xfer) begin
          if (hdrCnt_q == 1'(HDR_BYTES - 1)) begin
            n_d      = hdrN;
            hdrCnt_d = 1'b0;
            if (hdrN == 16'd0) begin
              state_d = ST_DONE;
            end else if (32'(hdrN) > 32'(DEPTH_WORDS)) begin
              state_d = ST_ERR;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            hdrHi_d  = Byte_Data;
            hdrCnt_d = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (wordReady) begin
          state_d = ST_WRITE;
          wdata_d = packWord;
          addr_d  = BASE_ADDR + (32'(idx_q) << 2);
        end
      end
      ST_WRITE: begin
        idx_d = idx_q + IDX_W'(1);
        if (32'(idx_q) + 32'd1 == 32'(n_q)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DATA;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset lands in IDLE with the address parked at the base.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      n_q      <= '0;
      hdrCnt_q <= 1'b0;
      hdrHi_q  <= '0;
      addr_q   <= BASE_ADDR;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      n_q      <= n_d;
      hdrCnt_q <= hdrCnt_d;
      hdrHi_q  <= hdrHi_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign IMem_WE    = (state_q == ST_WRITE);
  assign IMem_Addr  = addr_q;
  assign IMem_WData = wdata_q;
  assign Hold_CPU   = (state_q != ST_DONE);
  assign Done       = (state_q == ST_DONE);
  assign Error      = (state_q == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a stream-level model predicts every
// memory write when a load is issued; a monitor compares each write strobe.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0;
  logic        Byte_Valid = 1'b0;
  logic [7:0]  Byte_Data = 8'h00;
  logic        Byte_Ready, IMem_WE, Hold_CPU, Done, Error;
  logic [31:0] IMem_Addr, IMem_WData;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        expQ[$];
  logic [7:0] stream[$];
  int         vectors = 0;
  int         miscompares = 0;

  imem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .Start      (Start),
    .Byte_Valid (Byte_Valid),
    .Byte_Data  (Byte_Data),
    .Byte_Ready (Byte_Ready),
    .IMem_WE    (IMem_WE),
    .IMem_Addr  (IMem_Addr),
    .IMem_WData (IMem_WData),
    .Hold_CPU   (Hold_CPU),
    .Done       (Done),
    .Error      (Error)
  );

  // Free-running clock.
  always #5 Clock = ~Clock;

  // Hard stop if something hangs beyond any bounded wait.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every write strobe must match the oldest predicted write.
  always @(negedge Clock) begin
    wr_t e;
    if (IMem_WE !== 1'b0) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpectedWrite: got WE=%b addr 0x%08h data 0x%08h, expected no write",
                 IMem_WE, IMem_Addr, IMem_WData);
      end else begin
        e = expQ.pop_front();
        checkOutput("writeAddr", IMem_Addr, e.addr);
        checkOutput("writeData", IMem_WData, e.data);
        checkOutput("readyInWrite", {31'b0, Byte_Ready}, 32'd0);
      end
    end
  end

  // Reference model: decode the whole stream and predict the write list.
  task automatic modelLoad();
    int n;
    if (stream.size() < 2) return;
    n = {stream[0], stream[1]};
    if (n == 0 || n > DEPTH) return;
    for (int i = 0; i < n; i++) begin
      expQ.push_back(wr_t'{addr: BASE + 32'(4 * i),
                           data: {stream[2+4*i], stream[3+4*i],
                                  stream[4+4*i], stream[5+4*i]}});
    end
  endtask

  task automatic buildStream(input int n, input int words);
    stream.delete();
    stream.push_back(8'(n >> 8));
    stream.push_back(8'(n));
    for (int i = 0; i < 4 * words; i++) stream.push_back(8'($urandom));
  endtask

  task automatic pulseStart();
    @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  // Offer one byte after a gap; returns on the negedge after it transferred.
  task automatic sendByte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) @(negedge Clock);
    Byte_Valid = 1'b1;
    Byte_Data  = b;
    t = 0;
    while (Byte_Ready !== 1'b1 && t < 100) begin
      @(negedge Clock);
      t++;
    end
    if (t >= 100) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL byteAcceptTimeout: got Ready=%b for 100 cycles, expected 1", Byte_Ready);
    end
    @(negedge Clock);
    Byte_Valid = 1'b0;
    Byte_Data  = 8'($urandom);
  endtask

  // Issue a full load of 'stream'; gapMode >= 0 is a fixed gap, < 0 random 0..2.
  task automatic applyStimulus(input bit doStart, input int gapMode, input int midStartAt);
    int n;
    n = {stream[0], stream[1]};
    modelLoad();
    if (doStart) pulseStart();
    for (int i = 0; i < stream.size(); i++) begin
      sendByte(stream[i], (gapMode >= 0) ? gapMode : int'($urandom_range(2, 0)));
      if (i == midStartAt) pulseStart();
    end
    if (n == 0) begin
      checkOutput("emptyDone", {31'b0, Done}, 32'd1);
      checkOutput("emptyHold", {31'b0, Hold_CPU}, 32'd0);
    end else if (n > DEPTH) begin
      checkOutput("errFlag", {31'b0, Error}, 32'd1);
      checkOutput("errHold", {31'b0, Hold_CPU}, 32'd1);
      checkOutput("errDone", {31'b0, Done}, 32'd0);
    end else begin
      checkOutput("weLatency", {31'b0, IMem_WE}, 32'd1);
      @(negedge Clock);
      checkOutput("finalDone", {31'b0, Done}, 32'd1);
      checkOutput("finalHold", {31'b0, Hold_CPU}, 32'd0);
      checkOutput("finalError", {31'b0, Error}, 32'd0);
    end
    @(negedge Clock);
    checkOutput("pendingWrites", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    int n;
    $display("[TB] imem_loader bench starting");

    // Reset values while Reset_n is held low.
    repeat (2) @(negedge Clock);
    checkOutput("rstReady", {31'b0, Byte_Ready}, 32'd0);
    checkOutput("rstWE", {31'b0, IMem_WE}, 32'd0);
    checkOutput("rstAddr", IMem_Addr, BASE);
    checkOutput("rstWData", IMem_WData, 32'd0);
    checkOutput("rstHold", {31'b0, Hold_CPU}, 32'd1);
    checkOutput("rstDone", {31'b0, Done}, 32'd0);
    checkOutput("rstError", {31'b0, Error}, 32'd0);
    Reset_n = 1'b1;

    // Without Start the loader must ignore offered bytes.
    Byte_Valid = 1'b1;
    repeat (3) @(negedge Clock);
    checkOutput("idleReady", {31'b0, Byte_Ready}, 32'd0);
    checkOutput("idleHold", {31'b0, Hold_CPU}, 32'd1);
    Byte_Valid = 1'b0;

    // Directed two-word program, back-to-back bytes.
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    applyStimulus(1'b1, 0, -1);

    // Same program with three idle cycles before every byte.
    applyStimulus(1'b1, 3, -1);

    // Oversized header, then restart into HDR and finish with an empty load.
    stream = '{8'h01, 8'h01};
    applyStimulus(1'b1, 0, -1);
    pulseStart();
    checkOutput("restartError", {31'b0, Error}, 32'd0);
    checkOutput("restartReady", {31'b0, Byte_Ready}, 32'd1);
    checkOutput("restartDone", {31'b0, Done}, 32'd0);
    stream = '{8'h00, 8'h00};
    applyStimulus(1'b0, 0, -1);

    // Empty program started normally.
    applyStimulus(1'b1, 1, -1);

    // Reset mid-word, then a clean reload must start at the base address.
    stream = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    pulseStart();
    for (int i = 0; i < stream.size(); i++) sendByte(stream[i], 0);
    Reset_n = 1'b0;
    #1;
    checkOutput("midRstReady", {31'b0, Byte_Ready}, 32'd0);
    checkOutput("midRstHold", {31'b0, Hold_CPU}, 32'd1);
    checkOutput("midRstWE", {31'b0, IMem_WE}, 32'd0);
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clock);
    checkOutput("postRstIdle", {31'b0, Byte_Ready}, 32'd0);
    stream = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    applyStimulus(1'b1, 0, -1);

    // Start pulsed in the middle of word 0 must be ignored.
    buildStream(3, 3);
    applyStimulus(1'b1, -1, 3);

    // Randomised loads with random gaps.
    for (int k = 0; k < 5; k++) begin
      n = int'($urandom_range(6, 1));
      buildStream(n, n);
      applyStimulus(1'b1, -1, -1);
    end

    // Random oversized header.
    n = int'($urandom_range(65535, DEPTH + 1));
    buildStream(n, 0);
    applyStimulus(1'b1, -1, -1);

    // Full-depth load: last write lands at BASE + 4*(DEPTH-1).
    buildStream(DEPTH, DEPTH);
    applyStimulus(1'b1, 0, -1);

    repeat (3) @(negedge Clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
